memory_bus_arbiter: RTL and testbench

- Shares one memory bus between two requesters: port 0 (instruction fetch) and port 1 (data memory interface).
- Targets multicycle and pipelined core variants where fetch and load/store share a single unified memory.
- Accepts one transaction at a time from either port, drives the shared bus from registered copies of the request, and returns read data and a one-cycle done pulse to the granted port.

---
 rtl/memory_bus_arbiter_pkg.sv | 18 +
 rtl/memory_bus_arbiter_pick2.sv | 25 ++
 rtl/memory_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arbiter_state_t;

    localparam logic ARB_PORT_FETCH = 1'b0;
    localparam logic ARB_PORT_DATA  = 1'b1;

    // A write request suppresses the read strobe when both enables are set.
    function automatic logic bus_read_strobe(input logic read_en, input logic write_en);
        return read_en & ~write_en;
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_pick2.sv
// Combinational two-way winner selection: fixed priority to port 1 or
// round-robin against the previously granted port.
module arbiter_pick2
    import memory_bus_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_port_o
);

    always_comb begin
        grant_valid_o = |req_i;
        grant_port_o  = ARB_PORT_FETCH;
        case (req_i)
            2'b01:   grant_port_o = ARB_PORT_FETCH;
            2'b10:   grant_port_o = ARB_PORT_DATA;
            2'b11:   grant_port_o = FIXED_PRIORITY ? ARB_PORT_DATA : ~last_grant_i;
            default: grant_port_o = ARB_PORT_FETCH;
        endcase
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-port (fetch/data) arbiter for a single unified memory bus; one
// transaction at a time, bus driven from registered request copies.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [31:0]           m0_write_data,
    input  logic [3:0]            m0_byte_enable,
    input  logic                  m0_read_enable,
    input  logic                  m0_write_enable,
    output logic [31:0]           m0_read_data,
    output logic                  m0_ready,

    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [31:0]           m1_write_data,
    input  logic [3:0]            m1_byte_enable,
    input  logic                  m1_read_enable,
    input  logic                  m1_write_enable,
    output logic [31:0]           m1_read_data,
    output logic                  m1_ready,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic [3:0]            mem_byte_enable,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    input  logic [31:0]           mem_read_data,
    input  logic                  mem_ready
);

    arbiter_state_t        state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  re_q, re_d;
    logic                  we_q, we_d;
    logic [31:0]           result_q, result_d;

    logic [1:0]            req;
    logic                  pick_valid;
    logic                  pick_port;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic [3:0]            sel_be;
    logic                  sel_re;
    logic                  sel_we;
    logic                  resp_active;

    assign req[0] = m0_read_enable | m0_write_enable;
    assign req[1] = m1_read_enable | m1_write_enable;

    arbiter_pick2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .req_i         (req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (pick_valid),
        .grant_port_o  (pick_port)
    );

    always_comb begin
        if (pick_port == ARB_PORT_DATA) begin
            sel_addr  = m1_address;
            sel_wdata = m1_write_data;
            sel_be    = m1_byte_enable;
            sel_re    = m1_read_enable;
            sel_we    = m1_write_enable;
        end else begin
            sel_addr  = m0_address;
            sel_wdata = m0_write_data;
            sel_be    = m0_byte_enable;
            sel_re    = m0_read_enable;
            sel_we    = m0_write_enable;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        re_d         = re_q;
        we_d         = we_q;
        result_d     = result_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_port;
                    last_grant_d = pick_port;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    be_d         = sel_be;
                    re_d         = bus_read_strobe(sel_re, sel_we);
                    we_d         = sel_we;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ready) begin
                    result_d = we_q ? 32'h0 : mem_read_data;
                    state_d  = ARB_RESP;
                end
            end
            // No arbitration here, so a request still held through the pulse is not re-granted.
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= ARB_PORT_FETCH;
            last_grant_q <= ARB_PORT_DATA;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            re_q         <= re_d;
            we_q         <= we_d;
            result_q     <= result_d;
        end
    end

    assign resp_active      = (state_q == ARB_RESP);
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_byte_enable  = be_q;
    assign mem_read_enable  = (state_q == ARB_ISSUE) & re_q;
    assign mem_write_enable = (state_q == ARB_ISSUE) & we_q;

    assign m0_ready     = resp_active & (grant_q == ARB_PORT_FETCH);
    assign m1_ready     = resp_active & (grant_q == ARB_PORT_DATA);
    assign m0_read_data = m0_ready ? result_q : 32'h0;
    assign m1_read_data = m1_ready ? result_q : 32'h0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: one round-robin instance and one
// fixed-priority instance sharing clock, reset and the memory response.
module tb_memory_bus_arbiter;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_ready = 1'b0;

    // Round-robin instance
    logic [31:0] m0_address = 32'h0, m0_write_data = 32'h0;
    logic [3:0]  m0_byte_enable = 4'h0;
    logic        m0_read_enable = 1'b0, m0_write_enable = 1'b0;
    logic [31:0] m0_read_data;
    logic        m0_ready;
    logic [31:0] m1_address = 32'h0, m1_write_data = 32'h0;
    logic [3:0]  m1_byte_enable = 4'h0;
    logic        m1_read_enable = 1'b0, m1_write_enable = 1'b0;
    logic [31:0] m1_read_data;
    logic        m1_ready;
    logic [31:0] mem_address, mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_enable, mem_write_enable;

    // Fixed-priority instance
    logic [31:0] p0_address = 32'h0, p1_address = 32'h0;
    logic        p0_read_enable = 1'b0, p1_read_enable = 1'b0;
    logic [31:0] p0_read_data, p1_read_data;
    logic        p0_ready, p1_ready;
    logic [31:0] p_mem_address, p_mem_write_data;
    logic [3:0]  p_mem_byte_enable;
    logic        p_mem_read_enable, p_mem_write_enable;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    memory_bus_arbiter #(
        .FIXED_PRIORITY(1'b0),
        .ADDR_WIDTH    (32)
    ) dut (
        .clock           (clock),
        .reset           (rst_n),
        .m0_address      (m0_address),
        .m0_write_data   (m0_write_data),
        .m0_byte_enable  (m0_byte_enable),
        .m0_read_enable  (m0_read_enable),
        .m0_write_enable (m0_write_enable),
        .m0_read_data    (m0_read_data),
        .m0_ready        (m0_ready),
        .m1_address      (m1_address),
        .m1_write_data   (m1_write_data),
        .m1_byte_enable  (m1_byte_enable),
        .m1_read_enable  (m1_read_enable),
        .m1_write_enable (m1_write_enable),
        .m1_read_data    (m1_read_data),
        .m1_ready        (m1_ready),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_byte_enable (mem_byte_enable),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data),
        .mem_ready       (mem_ready)
    );

    memory_bus_arbiter #(
        .FIXED_PRIORITY(1'b1),
        .ADDR_WIDTH    (32)
    ) dut_fp (
        .clock           (clock),
        .reset           (rst_n),
        .m0_address      (p0_address),
        .m0_write_data   (32'h0),
        .m0_byte_enable  (4'hF),
        .m0_read_enable  (p0_read_enable),
        .m0_write_enable (1'b0),
        .m0_read_data    (p0_read_data),
        .m0_ready        (p0_ready),
        .m1_address      (p1_address),
        .m1_write_data   (32'h0),
        .m1_byte_enable  (4'hF),
        .m1_read_enable  (p1_read_enable),
        .m1_write_enable (1'b0),
        .m1_read_data    (p1_read_data),
        .m1_ready        (p1_ready),
        .mem_address     (p_mem_address),
        .mem_write_data  (p_mem_write_data),
        .mem_byte_enable (p_mem_byte_enable),
        .mem_read_enable (p_mem_read_enable),
        .mem_write_enable(p_mem_write_enable),
        .mem_read_data   (mem_read_data),
        .mem_ready       (mem_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        tick();
    endtask

    int cnt0, cnt1;
    logic exp_port;

    initial begin
        // Reset state
        #3;
        check_eq("rst_mem_re", 32'(mem_read_enable), 32'h0);
        check_eq("rst_mem_we", 32'(mem_write_enable), 32'h0);
        check_eq("rst_mem_addr", mem_address, 32'h0);
        check_eq("rst_m0_ready", 32'(m0_ready), 32'h0);
        check_eq("rst_m1_ready", 32'(m1_ready), 32'h0);
        check_eq("rst_fp_re", 32'(p_mem_read_enable), 32'h0);
        #4 rst_n = 1'b1;
        tick();

        // Test 1: reset during ISSUE abandons the transaction
        m0_address = 32'h100; m0_read_enable = 1'b1; mem_ready = 1'b0;
        tick();
        check_eq("t1_issue_re", 32'(mem_read_enable), 32'h1);
        check_eq("t1_issue_addr", mem_address, 32'h100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t1_async_re", 32'(mem_read_enable), 32'h0);
        check_eq("t1_async_addr", mem_address, 32'h0);
        check_eq("t1_async_ready", 32'(m0_ready), 32'h0);
        m0_read_enable = 1'b0;
        mem_ready = 1'b1;
        #10 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t1_no_ready", 32'(m0_ready), 32'h0);
            check_eq("t1_idle_re", 32'(mem_read_enable), 32'h0);
        end
        mem_ready = 1'b0;

        // Test 2: m0 read, memory ready on first ISSUE cycle (also the fresh request after reset)
        m0_address = 32'h40; m0_read_enable = 1'b1;
        check_eq("t2_n_ready", 32'(m0_ready), 32'h0);
        tick();
        check_eq("t2_n1_re", 32'(mem_read_enable), 32'h1);
        check_eq("t2_n1_we", 32'(mem_write_enable), 32'h0);
        check_eq("t2_n1_addr", mem_address, 32'h40);
        check_eq("t2_n1_ready", 32'(m0_ready), 32'h0);
        mem_ready = 1'b1; mem_read_data = 32'hDEAD_BEEF;
        tick();
        check_eq("t2_n2_ready", 32'(m0_ready), 32'h1);
        check_eq("t2_n2_data", m0_read_data, 32'hDEAD_BEEF);
        check_eq("t2_n2_m1_ready", 32'(m1_ready), 32'h0);
        check_eq("t2_n2_re", 32'(mem_read_enable), 32'h0);
        m0_read_enable = 1'b0; mem_ready = 1'b0;
        tick();
        check_eq("t2_n3_ready", 32'(m0_ready), 32'h0);
        check_eq("t2_n3_m1_ready", 32'(m1_ready), 32'h0);

        // Test 3: m1 write with three wait cycles
        m1_address = 32'h2000; m1_write_data = 32'h1234_5678; m1_byte_enable = 4'b0011;
        m1_write_enable = 1'b1; mem_read_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t3_we", 32'(mem_write_enable), 32'h1);
            check_eq("t3_re", 32'(mem_read_enable), 32'h0);
            check_eq("t3_addr", mem_address, 32'h2000);
            check_eq("t3_wdata", mem_write_data, 32'h1234_5678);
            check_eq("t3_be", 32'(mem_byte_enable), 32'h3);
            check_eq("t3_wait_ready", 32'(m1_ready), 32'h0);
        end
        mem_ready = 1'b1;
        tick();
        check_eq("t3_ready", 32'(m1_ready), 32'h1);
        check_eq("t3_rdata", m1_read_data, 32'h0);
        check_eq("t3_m0_ready", 32'(m0_ready), 32'h0);
        check_eq("t3_resp_we", 32'(mem_write_enable), 32'h0);
        check_eq("t3_resp_addr", mem_address, 32'h2000);
        m1_write_enable = 1'b0; mem_ready = 1'b0;
        tick();
        check_eq("t3_after_ready", 32'(m1_ready), 32'h0);

        // Test 4: round-robin with both ports requesting continuously
        apply_reset();
        m0_address = 32'hA0; m1_address = 32'hB0;
        m0_read_enable = 1'b1; m1_read_enable = 1'b1;
        mem_ready = 1'b1; mem_read_data = 32'h5555_AAAA;
        cnt0 = 0; cnt1 = 0;
        exp_port = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t4_issue_addr", mem_address, exp_port ? 32'hB0 : 32'hA0);
            tick();
            check_eq("t4_m0_ready", 32'(m0_ready), 32'(!exp_port));
            check_eq("t4_m1_ready", 32'(m1_ready), 32'(exp_port));
            cnt0 += int'(m0_ready);
            cnt1 += int'(m1_ready);
            tick();
            check_eq("t4_idle_ready", 32'({m1_ready, m0_ready}), 32'h0);
            exp_port = ~exp_port;
        end
        check_eq("t4_cnt0", 32'(cnt0), 32'd2);
        check_eq("t4_cnt1", 32'(cnt1), 32'd2);
        m0_read_enable = 1'b0; m1_read_enable = 1'b0; mem_ready = 1'b0;
        tick();
        tick();

        // Test 5: fixed priority, port 1 wins until it drops
        p0_address = 32'hC0; p1_address = 32'hD0;
        p0_read_enable = 1'b1; p1_read_enable = 1'b1; mem_ready = 1'b1;
        tick();
        check_eq("t5_first_addr", p_mem_address, 32'hD0);
        tick();
        check_eq("t5_p1_ready", 32'(p1_ready), 32'h1);
        check_eq("t5_p0_wait", 32'(p0_ready), 32'h0);
        p1_read_enable = 1'b0;
        tick();
        tick();
        check_eq("t5_second_addr", p_mem_address, 32'hC0);
        check_eq("t5_second_re", 32'(p_mem_read_enable), 32'h1);
        tick();
        check_eq("t5_p0_ready", 32'(p0_ready), 32'h1);
        check_eq("t5_p1_idle", 32'(p1_ready), 32'h0);
        p0_read_enable = 1'b0; mem_ready = 1'b0;
        tick();

        // Test 6: request held through RESP is not granted twice
        m0_address = 32'h300; m0_read_enable = 1'b1; mem_ready = 1'b1;
        mem_read_data = 32'h0BAD_F00D;
        tick();
        check_eq("t6_issue_re", 32'(mem_read_enable), 32'h1);
        tick();
        check_eq("t6_ready", 32'(m0_ready), 32'h1);
        check_eq("t6_rdata", m0_read_data, 32'h0BAD_F00D);
        tick();
        m0_read_enable = 1'b0;
        check_eq("t6_idle_re", 32'(mem_read_enable), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_no_regrant", 32'(mem_read_enable), 32'h0);
            check_eq("t6_no_ready", 32'(m0_ready), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
